// File: rtl/ph_waiter_pkg.sv
// Shared definitions for the dining-philosopher waiter: seat state encoding
// and ring-neighbour index helpers.
package ph_waiter_pkg;

    // Same 2-bit codes as the ring's THINKING/EATING encoding, plus HUNGRY.
    typedef enum logic [1:0] {
        ST_THINKING = 2'd0,
        ST_HUNGRY   = 2'd1,
        ST_EATING   = 2'd2
    } seat_state_t;

    localparam int MEAL_W = 4;
    localparam int WAIT_W = 8;

    function automatic int nbr_left(input int i, input int n);
        return (i + n - 1) % n;
    endfunction

    function automatic int nbr_right(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/ph_waiter_seat.sv
// One seat of the ring: THINKING/HUNGRY/EATING FSM, meal timer that forces
// release after EAT_MAX cycles, and a saturating wait counter for starvation.
module ph_seat
    import ph_waiter_pkg::*;
#(
    parameter int EAT_MAX    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hungry,
    input  logic       done,
    input  logic       grant,
    output logic       eat,
    output logic       cand,
    output logic       overdue,
    output logic [1:0] state
);

    localparam logic [MEAL_W-1:0] MEAL_LAST = MEAL_W'(EAT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(STARVE_LIM);

    seat_state_t       st, st_nxt;
    logic [MEAL_W-1:0] meal, meal_nxt, meal_inc;
    logic [WAIT_W-1:0] wcnt, wcnt_nxt;

    assign meal_inc = meal + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st   <= ST_THINKING;
            meal <= '0;
            wcnt <= '0;
        end else begin
            st   <= st_nxt;
            meal <= meal_nxt;
            wcnt <= wcnt_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        meal_nxt = meal;
        wcnt_nxt = wcnt;
        case (st)
            ST_THINKING: begin
                wcnt_nxt = '0;
                if (hungry) st_nxt = ST_HUNGRY;
            end
            ST_HUNGRY: begin
                // Withdrawal wins over a grant issued on the same edge.
                if (!hungry) begin
                    st_nxt   = ST_THINKING;
                    wcnt_nxt = '0;
                end else if (grant) begin
                    st_nxt   = ST_EATING;
                    meal_nxt = '0;
                    wcnt_nxt = '0;
                end else if (wcnt != WAIT_SAT) begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            ST_EATING: begin
                meal_nxt = meal_inc;
                // done and timeout together still give a single release.
                if (done || meal_inc == MEAL_LAST) begin
                    st_nxt   = ST_THINKING;
                    meal_nxt = '0;
                end
            end
            default: begin
                st_nxt   = ST_THINKING;
                meal_nxt = '0;
                wcnt_nxt = '0;
            end
        endcase
    end

    assign eat     = (st == ST_EATING);
    assign cand    = (st == ST_HUNGRY) && hungry;
    assign overdue = (wcnt >= WAIT_LIM);
    assign state   = st;

endmodule

// File: rtl/ph_waiter.sv
// Centralised fork waiter for an N-seat ring: round-robin grant scan over the
// seats, plus registered adjacency-violation and starvation flags.
module ph_waiter
    import ph_waiter_pkg::*;
#(
    parameter int N          = 8,
    parameter int EAT_MAX    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   hungry,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   eat,
    output logic [2*N-1:0] state,
    output logic           starve,
    output logic           safe,
    output logic           live
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  grant;
    logic [N-1:0]  cand;
    logic [N-1:0]  overdue;
    logic [N-1:0]  eat_nbr;
    logic [PW-1:0] ptr, ptr_nxt, last;
    logic [PW-1:0] seat_at [N];
    logic          any;

    for (genvar i = 0; i < N; i++) begin : g_seat
        ph_seat #(
            .EAT_MAX    (EAT_MAX),
            .STARVE_LIM (STARVE_LIM)
        ) u_seat (
            .clk     (clk),
            .reset   (reset),
            .hungry  (hungry[i]),
            .done    (done[i]),
            .grant   (grant[i]),
            .eat     (eat[i]),
            .cand    (cand[i]),
            .overdue (overdue[i]),
            .state   (state[2*i +: 2])
        );
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            seat_at[k] = PW'((int'(ptr) + k) % N);
        end
    end

    // Seats freed on this edge still count as eating; their forks open next edge.
    always_comb begin
        grant = '0;
        last  = ptr;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (cand[seat_at[k]]
                && !eat[PW'(nbr_left(int'(seat_at[k]), N))]
                && !eat[PW'(nbr_right(int'(seat_at[k]), N))]
                && !grant[PW'(nbr_left(int'(seat_at[k]), N))]
                && !grant[PW'(nbr_right(int'(seat_at[k]), N))]) begin
                grant[seat_at[k]] = 1'b1;
                last              = seat_at[k];
                any               = 1'b1;
            end
        end
        ptr_nxt = ptr;
        if (any) begin
            ptr_nxt = (last == PW'(N - 1)) ? '0 : last + 1'b1;
        end
    end

    assign eat_nbr = {eat[0], eat[N-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= '0;
            safe   <= 1'b0;
            starve <= 1'b0;
        end else begin
            ptr    <= ptr_nxt;
            safe   <= |(eat & eat_nbr);
            starve <= |overdue;
        end
    end

    assign live = eat[0];

endmodule

// File: tb/tb_ph_waiter.sv
// Randomised and directed bench for ph_waiter against a seat-level scheduling model.
module tb_ph_waiter;
    import ph_waiter_pkg::*;

    localparam int N          = 8;
    localparam int EAT_MAX    = 4;
    localparam int STARVE_LIM = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   hungry;
    logic [N-1:0]   done;
    logic [N-1:0]   eat;
    logic [2*N-1:0] state;
    logic           starve;
    logic           safe;
    logic           live;

    always #5 clk = ~clk;

    ph_waiter #(
        .N          (N),
        .EAT_MAX    (EAT_MAX),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .hungry (hungry),
        .done   (done),
        .eat    (eat),
        .state  (state),
        .starve (starve),
        .safe   (safe),
        .live   (live)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-seat state, remaining meal cycles, wait cycles.
    seat_state_t ms [N];
    int          meal_left [N];
    int          wt [N];
    int          mptr;
    bit          m_starve;
    bit          m_safe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_eat();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = (ms[i] == ST_EATING);
        return v;
    endfunction

    function automatic logic [2*N-1:0] m_state();
        logic [2*N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[2*i +: 2] = ms[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            ms[i] = ST_THINKING;
            meal_left[i] = 0;
            wt[i] = 0;
        end
        mptr = 0;
        m_starve = 0;
        m_safe = 0;
    endtask

    task automatic model_step(input logic [N-1:0] h, input logic [N-1:0] d);
        bit g [N];
        bit any, nsafe, nstarve;
        int last, i, l, r;
        any = 0; last = 0; nsafe = 0; nstarve = 0;
        for (int s = 0; s < N; s++) begin
            g[s] = 0;
            if (ms[s] == ST_EATING && ms[(s + 1) % N] == ST_EATING) nsafe = 1;
            if (wt[s] >= STARVE_LIM) nstarve = 1;
        end
        for (int k = 0; k < N; k++) begin
            i = (mptr + k) % N;
            l = (i + N - 1) % N;
            r = (i + 1) % N;
            if (ms[i] == ST_HUNGRY && h[i] && ms[l] != ST_EATING && ms[r] != ST_EATING
                && !g[l] && !g[r]) begin
                g[i] = 1;
                last = i;
                any = 1;
            end
        end
        for (int s = 0; s < N; s++) begin
            case (ms[s])
                ST_THINKING: begin
                    wt[s] = 0;
                    if (h[s]) ms[s] = ST_HUNGRY;
                end
                ST_HUNGRY: begin
                    if (!h[s]) begin
                        ms[s] = ST_THINKING;
                        wt[s] = 0;
                    end else if (g[s]) begin
                        ms[s] = ST_EATING;
                        meal_left[s] = EAT_MAX;
                        wt[s] = 0;
                    end else begin
                        wt[s] = (wt[s] < 255) ? wt[s] + 1 : 255;
                    end
                end
                default: begin
                    if (d[s] || meal_left[s] == 1) ms[s] = ST_THINKING;
                    else meal_left[s] = meal_left[s] - 1;
                end
            endcase
        end
        if (any) mptr = (last + 1) % N;
        m_safe = nsafe;
        m_starve = nstarve;
    endtask

    task automatic compare();
        check("eat", 32'(eat), 32'(m_eat()));
        check("state", 32'(state), 32'(m_state()));
        check("starve", 32'(starve), 32'(m_starve));
        check("safe", 32'(safe), 32'(m_safe));
        check("live", 32'(live), 32'(ms[0] == ST_EATING));
    endtask

    task automatic step(input logic [N-1:0] h, input logic [N-1:0] d);
        hungry = h;
        done = d;
        model_step(h, d);
        @(negedge clk);
        compare();
    endtask

    task automatic hit_reset();
        #1 reset = 1'b0;
        model_reset();
        #1 compare();
        @(negedge clk);
        compare();
        reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] h;
        bit saw_starve;

        reset = 1'b0;
        hungry = '1;
        done = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        reset = 1'b1;

        // All seats hungry from reset: evens first, then odds after the timeout.
        for (int c = 1; c <= 8; c++) begin
            step('1, '0);
            if (c == 2) check("all_55", 32'(eat), 32'h55);
            if (c == 6) check("all_gap", 32'(eat), 32'h00);
            if (c == 8) check("all_aa", 32'(eat), 32'hAA);
        end
        hit_reset();
        for (int c = 1; c <= 3; c++) begin
            step('1, '0);
            if (c == 2) check("restart_55", 32'(eat), 32'h55);
        end
        hit_reset();
        check("midmeal_rst", 32'(eat), 32'h00);
        for (int c = 1; c <= 2; c++) step('1, '0);
        check("ptr_restart", 32'(eat), 32'h55);

        // Single seat: four-cycle meal, two idle cycles, then eats again.
        hit_reset();
        for (int c = 1; c <= 9; c++) begin
            step(8'h08, '0);
            if (c >= 2 && c <= 5) check("single_eat", 32'(eat), 32'h08);
            if (c == 6 || c == 7) check("single_gap", 32'(eat), 32'h00);
            if (c == 8) check("single_again", 32'(eat), 32'h08);
        end

        // Wrap pair 7/0: seat 0 first, seat 7 one cycle after done[0].
        hit_reset();
        step(8'h81, '0);
        step(8'h81, '0);
        check("wrap_first", 32'(eat), 32'h01);
        step(8'h81, 8'h01);
        check("wrap_done", 32'(eat), 32'h00);
        step(8'h81, '0);
        check("wrap_seven", 32'(eat), 32'h80);

        // Seats 1 and 3 interleave meals so seat 2 starves, long enough to saturate.
        hit_reset();
        saw_starve = 0;
        step(8'h02, '0);
        for (int c = 2; c <= 4; c++) step(8'h06, '0);
        for (int c = 5; c <= 300; c++) begin
            step(8'h0E, '0);
            if (starve) saw_starve = 1;
        end
        check("starve_seen", 32'(saw_starve), 32'd1);
        check("starve_sat", 32'(starve), 32'd1);
        for (int c = 0; c < 20; c++) step(8'h04, '0);
        check("starve_clear", 32'(starve), 32'd0);

        // Withdrawal while waiting returns seat 2 to THINKING without a grant.
        hit_reset();
        step(8'h02, '0);
        step(8'h06, '0);
        step(8'h06, '0);
        step(8'h02, '0);
        check("withdraw_st", 32'(state[5:4]), 32'(ST_THINKING));
        for (int c = 0; c < 6; c++) step(8'h02, '0);
        check("withdraw_eat", 32'(eat[2]), 32'd0);

        // Random traffic with sparse done pulses and one reset in the middle.
        h = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5) == 0) h[i] = ~h[i];
            end
            step(h, N'($urandom & $urandom & $urandom));
            if (c == 1000) hit_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
